// File: rtl/y_pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// y_pc_sequencer_pkg
//   Shared definitions for the instruction sequencer and its control decoder:
//   opcode and ALU-op encodings, FSM state encoding, the decoded control
//   bundle and the next-PC arithmetic.
// -----------------------------------------------------------------------------
package y_pc_sequencer_pkg;

    // Major opcodes, ins[6:0]
    localparam logic [6:0] OPC_R    = 7'h33;
    localparam logic [6:0] OPC_LW   = 7'h03;
    localparam logic [6:0] OPC_ADDI = 7'h13;
    localparam logic [6:0] OPC_SW   = 7'h23;
    localparam logic [6:0] OPC_BEQ  = 7'h63;
    localparam logic [6:0] OPC_JAL  = 7'h6F;

    // ALU operation codes understood by yEX
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    // R-type function selector {funct7[5], funct3}
    localparam logic [3:0] FN_ADD = 4'b0_000;
    localparam logic [3:0] FN_SUB = 4'b1_000;
    localparam logic [3:0] FN_AND = 4'b0_111;
    localparam logic [3:0] FN_OR  = 4'b0_110;

    // Sequencer states
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Datapath control bundle
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic [2:0] op;
        logic       beq;
        logic       jal;
    } ctl_t;

    // Quiescent controls: no writes, ALU set up for a harmless imm add.
    localparam ctl_t CTL_IDLE = '{
        reg_write: 1'b0,
        alu_src:   1'b1,
        mem_read:  1'b0,
        mem_write: 1'b0,
        mem2reg:   1'b0,
        op:        ALU_ADD,
        beq:       1'b0,
        jal:       1'b0
    };

    // Next PC; all arithmetic is 32-bit modulo, wrap-around is intended.
    function automatic logic [31:0] next_pc(
        input logic [31:0] pc,
        input logic        take_branch,
        input logic        take_jal,
        input logic [31:0] imm,
        input logic [31:0] jtarget
    );
        if (take_branch) begin
            return pc + (imm << 1);
        end
        if (take_jal) begin
            return pc + (jtarget << 2);
        end
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/y_pc_sequencer_decode.sv
// -----------------------------------------------------------------------------
// y_ctl_decode
//   Purely combinational instruction decoder. Maps the opcode and R-type
//   function fields to the datapath control bundle and flags encodings the
//   datapath does not implement. Qualification by the sequencer state is done
//   by the caller.
// Ports
//   ins      in   32   instruction word
//   ctl      out  ctl_t decoded controls (unqualified)
//   illegal  out  1    unknown opcode or R-type function encoding
// -----------------------------------------------------------------------------
module y_ctl_decode
    import y_pc_sequencer_pkg::*;
(
    input  logic [31:0] ins,
    output ctl_t        ctl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [3:0] rfunct;
    logic       unused_ins_bits;

    assign opcode = ins[6:0];
    assign rfunct = {ins[30], ins[14:12]};

    // Register/immediate fields are consumed by yID, not by the decoder.
    assign unused_ins_bits = &{ins[31], ins[29:15], ins[11:7]};

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a value unassigned and no latch is inferred.
        ctl     = CTL_IDLE;
        illegal = 1'b0;

        case (opcode)
            OPC_R: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b0;
                case (rfunct)
                    FN_ADD:  ctl.op = ALU_ADD;
                    FN_SUB:  ctl.op = ALU_SUB;
                    FN_AND:  ctl.op = ALU_AND;
                    FN_OR:   ctl.op = ALU_OR;
                    default: begin
                        ctl.op  = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end

            OPC_LW: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.mem_read  = 1'b1;
                ctl.mem2reg   = 1'b1;
                ctl.op        = ALU_ADD;
            end

            OPC_ADDI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.op        = ALU_ADD;
            end

            OPC_SW: begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.op        = ALU_ADD;
            end

            OPC_BEQ: begin
                ctl.alu_src = 1'b0;
                ctl.op      = ALU_SUB;
                ctl.beq     = 1'b1;
            end

            OPC_JAL: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.op        = ALU_ADD;
                ctl.jal       = 1'b1;
            end

            // Unknown opcode executes as a NOP with the illegal flag raised.
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/y_pc_sequencer.sv
// -----------------------------------------------------------------------------
// y_pc_sequencer
//   Instruction sequencer in front of the yIF..yWB single-cycle datapath.
//   Each instruction takes two cycles: FETCH (yIF reads ins at PCin) and EXEC
//   (controls valid, datapath state commits on the closing edge). The PC and
//   retire counter advance on the edge that ends EXEC. After MAX_INSNS
//   retirements (0 = unlimited) the sequencer parks in HALT until rst.
// Parameters
//   RESET_PC   program entry point loaded on reset
//   MAX_INSNS  instruction budget before HALT; 0 runs forever
//   CNT_W      width of insn_count
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   ins         in   32     instruction from yIF
//   zero        in   1      ALU zero flag from yEX
//   imm         in   32     immediate from yID
//   jTarget     in   32     jump offset from yID
//   PCin        out  32     current PC to yIF
//   fetch       out  1      FETCH state
//   exec        out  1      EXEC state; controls valid
//   RegWrite    out  1      register-file write enable
//   ALUSrc      out  1      ALU B operand select (1 = imm)
//   MemRead     out  1      data-memory read enable
//   MemWrite    out  1      data-memory write enable
//   Mem2Reg     out  1      writeback select (1 = memOut)
//   op          out  3      ALU operation
//   beq         out  1      conditional branch in EXEC
//   jal         out  1      jump-and-link in EXEC
//   illegal     out  1      unknown encoding in EXEC
//   halted      out  1      HALT state
//   insn_count  out  CNT_W  instructions retired since reset (saturating)
// -----------------------------------------------------------------------------
module y_pc_sequencer
    import y_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h28,
    parameter int unsigned MAX_INSNS = 43,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic [31:0]      imm,
    input  logic [31:0]      jTarget,
    output logic [31:0]      PCin,
    output logic             fetch,
    output logic             exec,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic [2:0]       op,
    output logic             beq,
    output logic             jal,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] insn_count
);

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] count;

    ctl_t             dec_ctl;
    logic             dec_illegal;
    ctl_t             ctl;

    logic [31:0]      pc_next;
    logic [CNT_W-1:0] count_inc;
    logic             budget_done;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    y_ctl_decode u_decode (
        .ins     (ins),
        .ctl     (dec_ctl),
        .illegal (dec_illegal)
    );

    assign fetch  = (state == S_FETCH);
    assign exec   = (state == S_EXEC);
    assign halted = (state == S_HALT);

    // Controls are only meaningful while executing; otherwise hold idle.
    always_comb begin
        ctl = CTL_IDLE;
        if (exec) begin
            ctl = dec_ctl;
        end
    end

    // Write enables are also killed by rst so a reset landing on the closing
    // edge of EXEC cannot let a register or memory write commit.
    assign RegWrite = ctl.reg_write & ~rst;
    assign MemWrite = ctl.mem_write & ~rst;
    assign ALUSrc   = ctl.alu_src;
    assign MemRead  = ctl.mem_read;
    assign Mem2Reg  = ctl.mem2reg;
    assign op       = ctl.op;
    assign beq      = ctl.beq;
    assign jal      = ctl.jal;
    assign illegal  = exec & dec_illegal;

    assign PCin       = pc;
    assign insn_count = count;

    // ------------------------------------------------------------------
    // Next-state arithmetic
    // ------------------------------------------------------------------
    assign pc_next = next_pc(pc, dec_ctl.beq & zero, dec_ctl.jal, imm, jTarget);

    // Retire counter saturates rather than wrapping.
    assign count_inc = (count == '1) ? count : count + 1'b1;

    // Budget reached when the instruction now retiring is number MAX_INSNS.
    assign budget_done = (MAX_INSNS != 0) && (32'(count_inc) == MAX_INSNS);

    // ------------------------------------------------------------------
    // FSM, PC and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc    <= pc_next;
                    count <= count_inc;
                    state <= budget_done ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                // Unreachable encoding: park safely until the next reset.
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
